// File: rtl/sub_share_pkg.sv
// Shared definitions for the shared-subtractor arbiter: default sizes,
// the requester-id type and the saturation limits.
package sub_share_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_DW    = 12;
  localparam int DEF_LAT   = 2;

  // Requester index at the default requester count
  typedef logic [$clog2(DEF_N_REQ)-1:0] req_id_t;

  // Largest positive value representable in dw-bit two's complement
  function automatic int sat_max(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction

  // Most negative value representable in dw-bit two's complement
  function automatic int sat_min(input int dw);
    return -(1 << (dw - 1));
  endfunction

  localparam int SAT_MAX = sat_max(DEF_DW);
  localparam int SAT_MIN = sat_min(DEF_DW);

endpackage

// File: rtl/sub_share_arbiter_if.sv
// Request/result bundle of the shared-subtractor arbiter.
// Handshake: requester k's operand pair is accepted on a rising clock edge
// where i_req_valid[k] and o_req_ready[k] are both high; o_req_ready is a
// one-hot grant. Results have no backpressure: the consumer must take
// o_res_* in every cycle where o_res_valid is high.
interface sub_share_arbiter_if
  import sub_share_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int DW    = DEF_DW
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]    i_req_valid;
  logic [N_REQ-1:0]    o_req_ready;
  logic [N_REQ*DW-1:0] i_req_a;
  logic [N_REQ*DW-1:0] i_req_b;
  logic                o_res_valid;
  logic [IDW-1:0]      o_res_id;
  logic [DW-1:0]       o_res_data;
  logic                o_ovf;
  logic                o_busy;

  // Requester / consumer side
  modport master (
    output i_req_valid, i_req_a, i_req_b,
    input  o_req_ready, o_res_valid, o_res_id, o_res_data, o_ovf, o_busy
  );

  // Arbiter side
  modport slave (
    input  i_req_valid, i_req_a, i_req_b,
    output o_req_ready, o_res_valid, o_res_id, o_res_data, o_ovf, o_busy
  );

endinterface

// File: rtl/sub_share_pipe.sv
// Subtract-and-delay pipeline: stage 1 forms a - b at DW+1 bits, detects
// overflow and (with SUB_SHARE_ARBITER_SAT_EN defined) saturates; the result
// then travels through LAT-1 further register stages, so the output is
// valid LAT cycles after the accept edge.
module sub_share_pipe
  import sub_share_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int IDW = 2,
  parameter int LAT = DEF_LAT
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_valid,
  input  logic [IDW-1:0] i_id,
  input  logic [DW-1:0]  i_a,
  input  logic [DW-1:0]  i_b,
  output logic           o_valid,
  output logic [IDW-1:0] o_id,
  output logic [DW-1:0]  o_data,
  output logic           o_ovf,
  output logic           o_busy
);

`ifdef SUB_SHARE_ARBITER_SAT_EN
  localparam logic [DW-1:0] SAT_MAX_W = DW'(sat_max(DW));
  localparam logic [DW-1:0] SAT_MIN_W = DW'(sat_min(DW));
`endif

  logic [DW:0]    diff;
  logic           ovf_raw;
  logic [DW-1:0]  res;

  logic [LAT-1:0] valid_q, valid_d;
  logic [LAT-1:0] ovf_q, ovf_d;
  logic [IDW-1:0] id_q [LAT];
  logic [IDW-1:0] id_d [LAT];
  logic [DW-1:0]  data_q [LAT];
  logic [DW-1:0]  data_d [LAT];

  // Widened difference; overflow when the two top bits disagree
  always_comb begin
    diff    = {i_a[DW-1], i_a} - {i_b[DW-1], i_b};
    ovf_raw = diff[DW] ^ diff[DW-1];
    res     = diff[DW-1:0];
`ifdef SUB_SHARE_ARBITER_SAT_EN
    if (ovf_raw) begin
      res = diff[DW] ? SAT_MIN_W : SAT_MAX_W;
    end
`endif
  end

  // Stage 1 loads only on an accept; later stages shift every cycle
  always_comb begin
    valid_d    = '0;
    ovf_d      = '0;
    valid_d[0] = i_valid;
    ovf_d[0]   = i_valid & ovf_raw;
    id_d[0]    = i_valid ? i_id : id_q[0];
    data_d[0]  = i_valid ? res  : data_q[0];
    for (int i = 1; i < LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      ovf_d[i]   = ovf_q[i-1];
      id_d[i]    = id_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  // Pipeline registers; reset discards everything in flight
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= '0;
      ovf_q   <= '0;
      for (int i = 0; i < LAT; i++) begin
        id_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < LAT; i++) begin
        id_q[i]   <= id_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign o_valid = valid_q[LAT-1];
  assign o_ovf   = ovf_q[LAT-1];
  assign o_id    = id_q[LAT-1];
  assign o_data  = data_q[LAT-1];
  assign o_busy  = |valid_q;

endmodule

// File: rtl/sub_share_arbiter.sv
// Round-robin arbiter sharing one subtract pipeline among N_REQ requesters.
// The grant is combinational from the valid bits and the priority pointer;
// after a grant to k the pointer moves to k+1 so every continuously valid
// requester is served within N_REQ cycles.
// Optional feature macro: SUB_SHARE_ARBITER_SAT_EN (saturating results).
module sub_share_arbiter
  import sub_share_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int DW    = DEF_DW,
  parameter int LAT   = DEF_LAT
) (
  input  logic                i_clk,
  input  logic                i_rst,
  sub_share_arbiter_if.slave  bus
);

  localparam int IDW = $clog2(N_REQ);

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             gnt_any;
  logic [IDW-1:0]   gnt_idx;
  logic [N_REQ-1:0] ready;
  logic [DW-1:0]    sel_a;
  logic [DW-1:0]    sel_b;
  int               idx;

  // First valid requester at or after the pointer wins; nothing during reset
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!gnt_any && !i_rst && bus.i_req_valid[idx[IDW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[IDW-1:0];
      end
    end
  end

  // One-hot ready and operand selection for the granted requester
  always_comb begin
    ready = '0;
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_any && gnt_idx == IDW'(k)) begin
        ready[k] = 1'b1;
        sel_a    = bus.i_req_a[k*DW +: DW];
        sel_b    = bus.i_req_b[k*DW +: DW];
      end
    end
  end

  // Pointer advances past the winner and holds when nothing is granted
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Priority pointer register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign bus.o_req_ready = ready;

  sub_share_pipe #(
    .DW  (DW),
    .IDW (IDW),
    .LAT (LAT)
  ) u_pipe (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (gnt_any),
    .i_id    (gnt_idx),
    .i_a     (sel_a),
    .i_b     (sel_b),
    .o_valid (bus.o_res_valid),
    .o_id    (bus.o_res_id),
    .o_data  (bus.o_res_data),
    .o_ovf   (bus.o_ovf),
    .o_busy  (bus.o_busy)
  );

endmodule

// File: tb/tb_sub_share_arbiter.sv
// Bench for sub_share_arbiter: directed vector table, hand-written
// sequences and random traffic against a reference model built from the
// arbitration and arithmetic rules.
module tb_sub_share_arbiter;

  localparam int N    = 4;
  localparam int DW   = 12;
  localparam int LAT  = 2;
  localparam int MAXV = 2047;
  localparam int MINV = -2048;
`ifdef SUB_SHARE_ARBITER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sub_share_arbiter_if #(.N_REQ(N), .DW(DW)) bus ();

  sub_share_arbiter #(.N_REQ(N), .DW(DW), .LAT(LAT)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    int due;
    int id;
    int data;
    int ovf;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ptr    = 0;
  logic [N-1:0] obs_ready;
  bit obs_seen;
  int obs_id, obs_data, obs_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic from plain integers
  function automatic void model_sub(input int a, input int b, output int data, output int ovf);
    int d;
    d   = a - b;
    ovf = (d > MAXV || d < MINV) ? 1 : 0;
    if (SAT && d > MAXV) d = MAXV;
    if (SAT && d < MINV) d = MINV;
    data = d & ((1 << DW) - 1);
  endfunction

  // Compare result port and busy against what the model says is due now
  task automatic check_outputs();
    bit exp_v;
    exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    chk("busy", bus.o_busy, (exp_q.size() > 0) ? 1 : 0);
    chk("res_valid", bus.o_res_valid, exp_v);
    if (exp_v) begin
      chk("res_id", bus.o_res_id, exp_q[0].id);
      chk("res_data", bus.o_res_data, exp_q[0].data);
      chk("res_ovf", bus.o_ovf, exp_q[0].ovf);
      void'(exp_q.pop_front());
    end else begin
      chk("ovf_idle", bus.o_ovf, 0);
    end
    if (bus.o_res_valid) begin
      obs_seen = 1'b1;
      obs_id   = int'(bus.o_res_id);
      obs_data = int'(bus.o_res_data);
      obs_ovf  = int'(bus.o_ovf);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [N-1:0] v, input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
    int g;
    logic signed [DW-1:0] sa, sb;
    exp_t e;
    @(negedge clk);
    check_outputs();
    bus.i_req_valid = v;
    bus.i_req_a     = a;
    bus.i_req_b     = b;
    #1;
    g = -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (ptr + i) % N;
      if (g < 0 && v[k]) g = k;
    end
    obs_ready = bus.o_req_ready;
    chk("req_ready", bus.o_req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
    if (g >= 0) begin
      sa = a[g*DW +: DW];
      sb = b[g*DW +: DW];
      e.due = cyc + LAT;
      e.id  = g;
      model_sub(int'(sa), int'(sb), e.data, e.ovf);
      exp_q.push_back(e);
      ptr = (g + 1) % N;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_req_valid = '1;
    #1;
    chk("rst_ready", bus.o_req_ready, 0);
    chk("rst_res_valid", bus.o_res_valid, 0);
    chk("rst_res_id", bus.o_res_id, 0);
    chk("rst_res_data", bus.o_res_data, 0);
    chk("rst_ovf", bus.o_ovf, 0);
    chk("rst_busy", bus.o_busy, 0);
    repeat (2) @(negedge clk);
    chk("rst_ready_hold", bus.o_req_ready, 0);
    bus.i_req_valid = '0;
    rst = 1'b0;
    exp_q.delete();
    ptr = 0;
  endtask

  function automatic logic [N*DW-1:0] rand_ops();
    logic [N*DW-1:0] r;
    for (int k = 0; k < N; k++) begin
      case ($urandom_range(0, 5))
        0:       r[k*DW +: DW] = 12'h800;
        1:       r[k*DW +: DW] = 12'h7FF;
        default: r[k*DW +: DW] = DW'($urandom);
      endcase
    end
    return r;
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    int id;
    int a;
    int b;
    int exp_data;
    int exp_ovf;
  } vec_t;
  vec_t vecs[8];

  initial begin
    logic [N*DW-1:0] av, bv;

    vecs[0] = '{0, 100, 30, 'h046, 0};
    vecs[1] = '{1, -2048, 1, SAT ? 'h800 : 'h7FF, 1};
    vecs[2] = '{2, 2047, -1, SAT ? 'h7FF : 'h800, 1};
    vecs[3] = '{3, -2048, 2047, SAT ? 'h800 : 'h001, 1};
    vecs[4] = '{1, 2047, -2048, SAT ? 'h7FF : 'hFFF, 1};
    vecs[5] = '{2, -5, -5, 'h000, 0};
    vecs[6] = '{3, -1000, 1047, 'h801, 0};
    vecs[7] = '{0, 0, 1, 'hFFF, 0};

    bus.i_req_valid = '0;
    bus.i_req_a     = '0;
    bus.i_req_b     = '0;
    do_reset();

    // Single-request vectors; other slices carry noise that must be ignored
    for (int i = 0; i < 8; i++) begin
      av = rand_ops();
      bv = rand_ops();
      av[vecs[i].id*DW +: DW] = DW'(vecs[i].a);
      bv[vecs[i].id*DW +: DW] = DW'(vecs[i].b);
      obs_seen = 1'b0;
      step(N'(1 << vecs[i].id), av, bv);
      chk("vec_ready", obs_ready, 32'd1 << vecs[i].id);
      idle(LAT);
      chk("vec_seen", obs_seen, 1);
      chk("vec_id", obs_id, vecs[i].id);
      chk("vec_data", obs_data, vecs[i].exp_data);
      chk("vec_ovf", obs_ovf, vecs[i].exp_ovf);
    end
    idle(1);

    // All requesters valid from reset: strict 0,1,2,3 rotation
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step('1, rand_ops(), rand_ops());
      chk("rr_grant", obs_ready, 32'd1 << (i % N));
    end
    idle(LAT + 1);

    // Sparse: 2 alone, then 1 and 3 together twice
    do_reset();
    step(4'b0100, rand_ops(), rand_ops());
    chk("sparse_g2", obs_ready, 4'b0100);
    step(4'b1010, rand_ops(), rand_ops());
    chk("sparse_g3", obs_ready, 4'b1000);
    step(4'b1010, rand_ops(), rand_ops());
    chk("sparse_g1", obs_ready, 4'b0010);
    idle(LAT + 1);

    // Reset one cycle after an accept: the result must never appear
    do_reset();
    step(4'b0001, rand_ops(), rand_ops());
    step(4'b0000, '0, '0);
    do_reset();
    obs_seen = 1'b0;
    idle(5);
    chk("flush_no_result", obs_seen, 0);
    step(4'b1010, rand_ops(), rand_ops());
    chk("post_rst_grant", obs_ready, 4'b0010);
    idle(LAT + 1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(N'($urandom_range(0, 15)), rand_ops(), rand_ops());
    end
    idle(LAT + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sub_share_arbiter.md
SUB_SHARE_ARBITER -- requirements
Module: sub_share_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one subtract unit; range 2..8.
REQ-002 Parameter DW, default 12: signed two's-complement operand and result width.
REQ-003 Parameter LAT, default 2: accept-to-result latency in cycles; minimum 1.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 i_rst  input  1  asynchronous, active-high reset.
REQ-007 i_req_valid  input  N_REQ  per-requester operand-pair valid.
REQ-008 o_req_ready  output  N_REQ  one-hot grant; the pair is accepted when valid and ready are both high.
REQ-009 i_req_a  input  N_REQ*DW  minuend per requester; slice k is [k*DW +: DW].
REQ-010 i_req_b  input  N_REQ*DW  subtrahend per requester, using the same slicing.
REQ-011 o_res_valid  output  1  result valid for one cycle.
REQ-012 o_res_id  output  clog2(N_REQ)  index of the requester that owns the result.
REQ-013 o_res_data  output  DW  a minus b.
REQ-014 o_ovf  output  1  high with o_res_valid when the true difference is outside the DW range.
REQ-015 o_busy  output  1  high while any accepted operation is still in flight.

Function
REQ-016 At most one o_req_ready bit SHALL be high per cycle; it is combinational from i_req_valid and the priority pointer. All ready bits are 0 when no request is valid.
REQ-017 Arbitration SHALL be round-robin: search starts at pointer p. After a grant to k, p becomes (k+1) mod N_REQ. p is unchanged in cycles with no grant.
REQ-018 Ready SHALL NOT be granted while i_rst is high.
REQ-019 The difference SHALL be formed at DW+1 bits from sign-extended operands. This includes the a=min, b=max case, e.g. -2048-2047 at DW=12.
REQ-020 The result SHALL appear exactly LAT cycles after the accept edge, with its id, o_ovf and o_res_valid aligned to it.
REQ-021 The unit SHALL be fully pipelined: one accept per cycle, back-to-back, with no bubbles.
REQ-022 The output has no backpressure; the consumer SHALL sample o_res_* whenever o_res_valid is high.
REQ-023 o_busy = OR of all pipeline-stage valid bits. It excludes the current-cycle accept.
REQ-024 A requester that holds valid continuously is granted at least once every N_REQ cycles.

Reset
REQ-025 While i_rst is asserted: p=0, all pipeline valid bits cleared, o_res_valid=0, o_res_id=0, o_res_data=0, o_ovf=0, o_busy=0, o_req_ready=0.
REQ-026 Reset mid-operation SHALL discard all in-flight results; none is emitted after release.
REQ-027 The first grant after release SHALL go to the lowest-index valid requester.

Configuration
REQ-028 Macro SUB_SHARE_ARBITER_SAT_EN defined: out-of-range results saturate to 2^(DW-1)-1 or -2^(DW-1), and o_ovf pulses.
REQ-029 Macro undefined: the result is the low DW bits of the difference, wrap-around. o_ovf still reports the overflow.

Structure
REQ-030 Shared package sub_share_pkg SHALL hold:
- default DW, N_REQ and LAT;
- the requester-id typedef;
- SAT_MAX and SAT_MIN constants as functions of DW.
REQ-031 The subtract-and-delay path SHALL be a single sub-module sub_share_pipe:
- inputs: operands, id and valid;
- subtraction in stage 1, optional saturation, then an (LAT-1)-deep register delay;
- outputs: data, id, ovf and valid.
REQ-032 sub_share_arbiter SHALL contain the arbiter, the pointer, operand muxing, and the sub_share_pipe instance.

Verification
REQ-033 Single request: req0 valid, a=100, b=30 -> ready0 the same cycle. LAT=2 cycles later: o_res_valid=1, id=0, data=70, ovf=0. Then o_busy=0.
REQ-034 All four valid continuously from reset -> grants 0,1,2,3,0,... one per cycle, and results return in that id order.
REQ-035 Overflow: a=-2048, b=1 at DW=12 -> with SAT_EN: data=-2048 (0x800), ovf=1. Without SAT_EN: data=2047 (0x7FF), ovf=1.
REQ-036 Positive overflow: a=2047, b=-1 -> with SAT_EN: 2047, ovf=1. Without SAT_EN: -2048, ovf=1.
REQ-037 Reset mid-flight: assert i_rst one cycle after an accept -> no o_res_valid within 5 cycles after release. The next grant goes to the lowest valid index.
REQ-038 Sparse requests: req2 valid alone, then req1 and req3 together -> grants go to 2, then 3 (pointer at 3), then 1.
